// File: rtl/dds_key_ctrl.sv
// Key-driven DDS configuration: wave key cycles the waveform, freq key steps the frequency index.
// Define DDS_KEY_CTRL_AUTOREPEAT_EN to enable hold-to-repeat on the frequency key.
module dds_key_ctrl #(
  parameter int unsigned HOLD_TICKS   = 25_000_000,
  parameter int unsigned REPEAT_TICKS = 5_000_000,
  parameter logic [31:0] FWORD_STEP   = 32'd85899,
  parameter int unsigned IDX_MAX      = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        wave_flag,
  input  logic        freq_flag,
  output logic [1:0]  wave_sel,
  output logic [7:0]  freq_idx,
  output logic [31:0] fword,
  output logic        cfg_update
);

  localparam logic [7:0] IDX_TOP = 8'(IDX_MAX);

`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_REPEAT = 2'd2} state_t;

  localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;

  logic [63:0] unused_ticks_s;
  assign unused_ticks_s = {32'(HOLD_TICKS), 32'(REPEAT_TICKS)};
`endif

  state_t      state_r;
  state_t      state_nxt_s;
  logic        wave_pressed_r;
  logic        freq_pressed_r;
  logic [1:0]  wave_sel_r;
  logic [7:0]  freq_idx_r;
  logic [31:0] fword_r;
  logic        cfg_update_r;

  logic        wave_press_s;
  logic        freq_press_s;
  logic        freq_rel_s;
  logic        freq_inc_s;
  logic [7:0]  idx_wrap_s;
  logic [31:0] fword_nxt_s;

  // Flags alternate press/release, so the pressed bit tells which one a pulse is
  assign wave_press_s = wave_flag & ~wave_pressed_r;
  assign freq_press_s = freq_flag & ~freq_pressed_r;
  assign freq_rel_s   = freq_flag &  freq_pressed_r;

  // Next frequency index wraps back to 1, never to 0
  always_comb begin
    if (freq_idx_r >= IDX_TOP) begin
      idx_wrap_s = 8'd1;
    end else begin
      idx_wrap_s = freq_idx_r + 8'd1;
    end
    fword_nxt_s = FWORD_STEP * {24'd0, idx_wrap_s};
  end

  // Freq key FSM; a release always beats a same-cycle timer expiry
  always_comb begin
    state_nxt_s = state_r;
    freq_inc_s  = 1'b0;
`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
    cnt_nxt_s   = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (freq_press_s) begin
          state_nxt_s = ST_HOLD;
          freq_inc_s  = 1'b1;
`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
          cnt_nxt_s   = '0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (freq_rel_s) begin
          state_nxt_s = ST_IDLE;
`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
          cnt_nxt_s   = '0;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_REPEAT;
          freq_inc_s  = 1'b1;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
`else
        end else begin
          state_nxt_s = ST_HOLD;
`endif
        end
      end
`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (freq_rel_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else if (cnt_r == REPEAT_LAST) begin
          freq_inc_s  = 1'b1;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
  // Hold / repeat cycle counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  // Key tracking, configuration registers and update strobe
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r        <= ST_IDLE;
      wave_pressed_r <= 1'b0;
      freq_pressed_r <= 1'b0;
      wave_sel_r     <= 2'd0;
      freq_idx_r     <= 8'd1;
      fword_r        <= FWORD_STEP;
      cfg_update_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      wave_pressed_r <= wave_pressed_r ^ wave_flag;
      freq_pressed_r <= freq_pressed_r ^ freq_flag;
      if (wave_press_s) begin
        wave_sel_r <= wave_sel_r + 2'd1;
      end
      if (freq_inc_s) begin
        freq_idx_r <= idx_wrap_s;
        fword_r    <= fword_nxt_s;
      end
      cfg_update_r   <= wave_press_s | freq_inc_s;
    end
  end

  assign wave_sel   = wave_sel_r;
  assign freq_idx   = freq_idx_r;
  assign fword      = fword_r;
  assign cfg_update = cfg_update_r;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl with short hold/repeat times.
module tb_dds_key_ctrl;

  localparam logic [31:0] STEP = 32'd100;
`ifdef DDS_KEY_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        wave_flag = 1'b0;
  logic        freq_flag = 1'b0;
  logic [1:0]  wave_sel;
  logic [7:0]  freq_idx;
  logic [31:0] fword;
  logic        cfg_update;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       w;
    logic       f;
    logic [1:0] ew;
    logic [7:0] ei;
    logic       ec;
  } vec_t;

  vec_t vecs[17];

  always #5 Clk = ~Clk;

  dds_key_ctrl #(
    .HOLD_TICKS  (10),
    .REPEAT_TICKS(4),
    .FWORD_STEP  (STEP),
    .IDX_MAX     (4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wave_flag (wave_flag),
    .freq_flag (freq_flag),
    .wave_sel  (wave_sel),
    .freq_idx  (freq_idx),
    .fword     (fword),
    .cfg_update(cfg_update)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ew, input logic [7:0] ei, input logic ec);
    chk({tag, ".wave_sel"},   32'(wave_sel),   32'(ew));
    chk({tag, ".freq_idx"},   32'(freq_idx),   32'(ei));
    chk({tag, ".fword"},      fword,           32'(ei) * STEP);
    chk({tag, ".cfg_update"}, 32'(cfg_update), 32'(ec));
  endtask

  task automatic tick(input logic w, input logic f);
    wave_flag = w;
    freq_flag = f;
    @(posedge Clk);
    #1;
    wave_flag = 1'b0;
    freq_flag = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    int ninc;
    logic [7:0] ei;
    logic ec;

    // wave presses/releases, short freq press, simultaneous keys
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 8'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 8'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 8'd1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 8'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 8'd1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'd2, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 8'd2, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'd1, 8'd3, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 2'd1, 8'd3, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd1, 8'd3, 1'b0};

    // asynchronous reset, checked before any clock edge
    #2 Reset_n = 1'b0;
    #1 chk_all("rst.async", 2'd0, 8'd1, 1'b0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0);
      chk_all($sformatf("idle.c%0d", k), 2'd0, 8'd1, 1'b0);
    end

    for (int v = 0; v < 17; v++) begin
      tick(vecs[v].w, vecs[v].f);
      chk_all($sformatf("vec%0d", v), vecs[v].ew, vecs[v].ei, vecs[v].ec);
    end

    // long hold: repeats at +10, +14, +18, +22 with wrap 4 -> 1
    do_reset();
    tick(1'b0, 1'b1);
    chk_all("hold.press", 2'd0, 8'd2, 1'b1);
    for (int k = 1; k <= 22; k++) begin
      tick(1'b0, 1'b0);
      ninc = 1;
      if (AR && k >= 10) ninc++;
      if (AR && k >= 14) ninc++;
      if (AR && k >= 18) ninc++;
      if (AR && k >= 22) ninc++;
      ei = 8'((ninc % 4) + 1);
      ec = AR && (k == 10 || k == 14 || k == 18 || k == 22);
      chk_all($sformatf("hold.k%0d", k), 2'd0, ei, ec);
    end
    tick(1'b0, 1'b1);
    chk_all("hold.release", 2'd0, 8'd2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0);
      chk_all($sformatf("hold.after%0d", k), 2'd0, 8'd2, 1'b0);
    end

    // release on the same cycle as hold expiry: no increment
    do_reset();
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) tick(1'b0, 1'b0);
    chk_all("race.pre", 2'd0, 8'd2, 1'b0);
    tick(1'b0, 1'b1);
    chk_all("race.release", 2'd0, 8'd2, 1'b0);
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b0);
    chk_all("race.idle", 2'd0, 8'd2, 1'b0);

    // reset 12 cycles into a held press
    do_reset();
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) tick(1'b0, 1'b0);
    chk_all("midrst.pre", 2'd0, AR ? 8'd3 : 8'd2, 1'b0);
    Reset_n = 1'b0;
    #2 chk_all("midrst.async", 2'd0, 8'd1, 1'b0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 1'b0);
      chk_all($sformatf("midrst.c%0d", k), 2'd0, 8'd1, 1'b0);
    end
    tick(1'b0, 1'b1);
    chk_all("midrst.press", 2'd0, 8'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
